// File: rtl/bp_pkg.sv
// bp_pkg: shared state enum, default sizes and counter init value for the branch history table
package bp_pkg;
  typedef enum logic {INIT, RUN} bp_state_e;
  localparam int DEF_IDX_BITS = 6;
  localparam int DEF_CTR_WIDTH = 2;
  function automatic int weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/bp_ctr_next.sv
// bp_ctr_next: saturating up/down next-value for one history counter
module bp_ctr_next #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         taken,
  output logic [W-1:0] nxt
);
  always_comb nxt = taken ? (&ctr ? ctr : ctr + 1'b1) : (|ctr ? ctr - 1'b1 : ctr);
endmodule

// File: rtl/bp_bht.sv
// bp_bht: untagged saturating-counter branch history table; BP_BHT_BYPASS_EN forwards same-cycle updates to lookups
module bp_bht
  import bp_pkg::*;
#(
  parameter int IDX_BITS  = DEF_IDX_BITS,
  parameter int CTR_WIDTH = DEF_CTR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        guess_valid,
  input  logic [31:0] guess_pc,
  output logic        guess_out_valid,
  output logic        guess_taken,
  input  logic        check_valid,
  input  logic [31:0] check_pc,
  input  logic        check_taken
);
  localparam logic [CTR_WIDTH-1:0] WNT = CTR_WIDTH'(weak_nt(CTR_WIDTH));
  bp_state_e state, state_nxt;
  logic [IDX_BITS-1:0] init_idx, g_idx, c_idx;
  logic [CTR_WIDTH-1:0] bht [2**IDX_BITS];
  logic [CTR_WIDTH-1:0] c_nxt;
  logic upd, g_msb, unused_pc;
  assign g_idx = guess_pc[IDX_BITS+1:2];
  assign c_idx = check_pc[IDX_BITS+1:2];
  assign unused_pc = ^{guess_pc[31:IDX_BITS+2], guess_pc[1:0], check_pc[31:IDX_BITS+2], check_pc[1:0]};
  bp_ctr_next #(.W(CTR_WIDTH)) u_ctr_next (.ctr(bht[c_idx]), .taken(check_taken), .nxt(c_nxt));
  always_ff @(posedge clk) state <= rst ? INIT : state_nxt;
  always_comb state_nxt = (state == INIT && &init_idx) ? RUN : state;
  always_comb begin
    ready = state == RUN;
    upd = ready && check_valid && !rst;
  end
`ifdef BP_BHT_BYPASS_EN
  always_comb g_msb = (upd && c_idx == g_idx) ? c_nxt[CTR_WIDTH-1] : bht[g_idx][CTR_WIDTH-1];
`else
  always_comb g_msb = bht[g_idx][CTR_WIDTH-1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx <= '0;
      guess_out_valid <= 1'b0;
      guess_taken <= 1'b0;
    end else begin
      if (!ready) init_idx <= init_idx + 1'b1;
      guess_out_valid <= guess_valid;
      guess_taken <= guess_valid && ready && g_msb;
    end
  end
  // storage carries no reset: INIT rewrites every entry before lookups are honoured
  always_ff @(posedge clk) begin
    if (!ready) bht[init_idx] <= WNT;
    else if (upd) bht[c_idx] <= c_nxt;
  end
endmodule

// File: tb/tb_bp_bht.sv
// tb_bp_bht: vector table, corner sequences and random traffic against a behavioural predictor model
module tb_bp_bht;
  logic clk = 0, rst = 0, ready, guess_valid = 0, guess_out_valid, guess_taken;
  logic check_valid = 0, check_taken = 0;
  logic [31:0] guess_pc = 0, check_pc = 0;
  int nc = 0, nf = 0;
  int mem [64];
  int left = 64;
  bit e_gov, e_gt;

  bp_bht dut (.clk(clk), .rst(rst), .ready(ready), .guess_valid(guess_valid), .guess_pc(guess_pc),
              .guess_out_valid(guess_out_valid), .guess_taken(guess_taken), .check_valid(check_valid),
              .check_pc(check_pc), .check_taken(check_taken));

  always #5 clk = ~clk;

  typedef struct {
    bit rs; bit gv; logic [31:0] gp; bit cv; logic [31:0] cp; bit ct; bit eov; bit et;
  } vec_t;
  vec_t v [$];

  task automatic chk(input string name, input logic act, input logic exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction

  // predictor model: counters 0..3, taken when counter >= 2, 64 cycles of warm-up after reset
  task automatic model(input bit r, gv, input logic [31:0] gp, input bit cv, input logic [31:0] cp, input bit ct);
    int pre, post;
    bit rdy;
    if (r) begin
      e_gov = 0; e_gt = 0; left = 64;
      foreach (mem[i]) mem[i] = 1;
    end else begin
      rdy = left == 0;
      pre = mem[idx(gp)];
      if (rdy && cv) mem[idx(cp)] = ct ? (mem[idx(cp)] < 3 ? mem[idx(cp)] + 1 : 3)
                                       : (mem[idx(cp)] > 0 ? mem[idx(cp)] - 1 : 0);
      post = mem[idx(gp)];
`ifdef BP_BHT_BYPASS_EN
      e_gt = gv && rdy && post >= 2;
`else
      e_gt = gv && rdy && pre >= 2;
`endif
      e_gov = gv;
      if (!rdy) left--;
    end
  endtask

  task automatic cyc(input bit r, gv, input logic [31:0] gp, input bit cv, input logic [31:0] cp, input bit ct);
    rst = r; guess_valid = gv; guess_pc = gp; check_valid = cv; check_pc = cp; check_taken = ct;
    model(r, gv, gp, cv, cp, ct);
    @(posedge clk);
    #1;
    chk("ready", ready, left == 0);
    chk("guess_out_valid", guess_out_valid, e_gov);
    chk("guess_taken", guess_taken, e_gt);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 1, 32'h100, 1, 32'h100, 1);
    chk("rst_gov", guess_out_valid, 1'b0);
    chk("rst_ready", ready, 1'b0);
    idle(64);
    chk("init_done", ready, 1'b1);
  endtask

  initial begin
    // reset, warm-up length and a lookup during warm-up
    cyc(1, 1, 0, 0, 0, 0);
    chk("r_ready0", ready, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      cyc(0, k == 10, 32'h100, k == 20, 32'h100, 1);
      chk("r_ready", ready, k == 64);
      if (k == 10) begin
        chk("init_gov", guess_out_valid, 1'b1);
        chk("init_gt", guess_taken, 1'b0);
      end
    end
    // update during warm-up was dropped: counter still weakly not-taken
    cyc(0, 1, 32'h100, 0, 0, 0);
    chk("init_drop", guess_taken, 1'b0);

    v.push_back('{1, 0, 0, 1, 32'h100, 1, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h100, 1, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h100, 1, 0, 0});
    v.push_back('{0, 1, 32'h100, 0, 0, 0, 1, 1});
    v.push_back('{0, 0, 0, 1, 32'h100, 0, 0, 0});
    v.push_back('{0, 1, 32'h100, 0, 0, 0, 1, 1});
    v.push_back('{0, 0, 0, 1, 32'h100, 0, 0, 0});
    v.push_back('{0, 1, 32'h100, 0, 0, 0, 1, 0});
    v.push_back('{1, 0, 0, 1, 32'h200, 0, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h200, 0, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h200, 0, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h200, 0, 0, 0});
    v.push_back('{0, 1, 32'h200, 0, 0, 0, 1, 0});
    v.push_back('{0, 1, 32'h200, 1, 32'h200, 1, 1, 0});
    v.push_back('{0, 1, 32'h200, 0, 0, 0, 1, 0});
    v.push_back('{1, 0, 0, 1, 32'h004, 1, 0, 0});
    v.push_back('{0, 0, 0, 1, 32'h004, 1, 0, 0});
    v.push_back('{0, 1, 32'h104, 0, 0, 0, 1, 1});
    v.push_back('{0, 1, 32'h104, 1, 32'h008, 1, 1, 1});
    v.push_back('{0, 1, 32'h008, 1, 32'h004, 0, 1, 1});
    v.push_back('{0, 1, 32'h004, 0, 0, 0, 1, 1});
    foreach (v[i]) begin
      if (v[i].rs) do_reset();
      cyc(0, v[i].gv, v[i].gp, v[i].cv, v[i].cp, v[i].ct);
      chk($sformatf("vec%0d_gov", i), guess_out_valid, v[i].eov);
      chk($sformatf("vec%0d_gt", i), guess_taken, v[i].et);
    end

    // same-cycle lookup and update on one index
    do_reset();
    cyc(0, 1, 32'h300, 1, 32'h300, 1);
`ifdef BP_BHT_BYPASS_EN
    chk("same_idx", guess_taken, 1'b1);
`else
    chk("same_idx", guess_taken, 1'b0);
`endif
    cyc(0, 1, 32'h300, 0, 0, 0);
    chk("same_idx_after", guess_taken, 1'b1);

    // reset in RUN wipes trained state
    repeat (3) cyc(0, 0, 0, 1, 32'h100, 1);
    cyc(0, 1, 32'h100, 0, 0, 0);
    chk("trained", guess_taken, 1'b1);
    cyc(1, 1, 32'h100, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      cyc(0, 0, 0, 1, 32'h100, 1);
      chk("rerun_ready", ready, k == 64);
    end
    cyc(0, 1, 32'h100, 0, 0, 0);
    chk("rerun_gt", guess_taken, 1'b0);

    // reset mid-warm-up restarts from index 0
    cyc(1, 0, 0, 0, 0, 0);
    idle(30);
    cyc(1, 0, 0, 0, 0, 0);
    idle(63);
    chk("mid_init_ready", ready, 1'b0);
    idle(1);
    chk("mid_init_done", ready, 1'b1);

    // random traffic over a few colliding indices with stray high/low pc bits
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] gp, cp;
      gp = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      cp = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      cyc($urandom_range(0, 299) == 0, 1'($urandom), gp, 1'($urandom), cp, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/bp_bht.md
BP_BHT -- requirements
Module: bp_bht

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 6, giving log2 of the table entry count (64 entries).
REQ-002 The block SHALL have parameter CTR_WIDTH, default 2, giving the width of each saturating counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port ready, output, 1: table initialised, lookups and updates accepted.
REQ-006 The block SHALL have port guess_valid, input, 1: prediction lookup request this cycle.
REQ-007 The block SHALL have port guess_pc, input, 32: PC of the lookup.
REQ-008 The block SHALL have port guess_out_valid, output, 1: guess_taken is valid this cycle.
REQ-009 The block SHALL have port guess_taken, output, 1: predicted direction, 1 means taken.
REQ-010 The block SHALL have port check_valid, input, 1: a resolved-branch update is present this cycle.
REQ-011 The block SHALL have port check_pc, input, 32: PC of the resolved branch.
REQ-012 The block SHALL have port check_taken, input, 1: actual resolved direction.

Function
REQ-013 Table SHALL hold 2^IDX_BITS counters of CTR_WIDTH bits, indexed by pc[IDX_BITS+1:2]; no tags, aliasing permitted.
REQ-014 FSM SHALL have states INIT and RUN; rst forces INIT with init index 0.
REQ-015 In INIT, one entry per cycle SHALL be written with weakly-not-taken (MSB 0, all other bits 1; 2'b01 at default); after the last index, state becomes RUN next cycle.
REQ-016 ready SHALL be 1 only in RUN; INIT lasts exactly 2^IDX_BITS cycles after rst deasserts.
REQ-017 Lookup SHALL have 1-cycle latency: guess_valid at cycle N gives guess_out_valid=1 and guess_taken=counter MSB at N+1.
REQ-018 guess_valid in INIT SHALL yield guess_out_valid=1, guess_taken=0 at N+1.
REQ-019 Update SHALL be a single-cycle read-modify-write: check_taken=1 increments, 0 decrements the indexed counter, written at the clock edge.
REQ-020 Counter arithmetic SHALL saturate: increment at all-ones and decrement at zero leave the value unchanged; no wrap-around.
REQ-021 check_valid in INIT SHALL be dropped with no table change.
REQ-022 Back-to-back updates to one index SHALL accumulate, each cycle using the value written the cycle before.
REQ-023 Same-cycle lookup and update to different indices SHALL both complete independently.

Reset
REQ-024 rst SHALL force ready=0, guess_out_valid=0, guess_taken=0 on the next edge and discard any pending lookup.
REQ-025 rst asserted mid-INIT or mid-RUN SHALL restart INIT from index 0; the whole table is reinitialised.

Configuration
REQ-026 Macro BP_BHT_BYPASS_EN defined: a same-cycle lookup and update to the same index SHALL return the MSB of the post-update counter.
REQ-027 Macro BP_BHT_BYPASS_EN undefined: that same-cycle lookup SHALL return the MSB of the pre-update counter.

Structure
REQ-028 A shared package bp_pkg SHALL hold the state enum (INIT, RUN), the default IDX_BITS/CTR_WIDTH constants and the weakly-not-taken init-value function.
REQ-029 The saturating next-counter computation SHALL be one sub-module, bp_ctr_next (inputs counter, taken; output next counter); all table storage and the FSM stay in bp_bht.

Verification
REQ-030 rst high 1 cycle, then low: ready=0 for 64 cycles, 1 on cycle 65; guess at cycle 10 gives guess_out_valid=1, guess_taken=0.
REQ-031 After init, three updates taken at pc 0x100: counter 01->10->11->11; guess at 0x100 gives taken=1; two not-taken updates give 01, taken=0.
REQ-032 Four not-taken updates at pc 0x200 from init: counter 01->00->00->00, no wrap to 11; guess_taken=0.
REQ-033 Same cycle: update taken at 0x300 (counter 01) and guess at 0x300: with BP_BHT_BYPASS_EN guess_taken=1, without guess_taken=0.
REQ-034 Aliasing: update taken twice at 0x004, then guess at 0x104 (same index at IDX_BITS=6) gives guess_taken=1.
REQ-035 rst pulsed in RUN after training 0x100 to 11: ready=0 for 64 cycles, then guess at 0x100 gives guess_taken=0.
